// File: rtl/mash11_modulator.sv
// mash11_modulator: MASH 1-1 delta-sigma modulator with tick divider and one-entry AXI-Stream input buffer.
// Optional build macro MASH11_DITHER_EN adds a 16-bit LFSR whose LSB dithers the stage-1 input.
module mash11_modulator #(
    parameter int WIDTH   = 16,
    parameter int OSR_DIV = 1
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic [WIDTH-1:0] s_axis_data_tdata,
    input  logic             s_axis_data_tvalid,
    output logic             s_axis_data_tready,
    output logic [1:0]       m_dac_code,
    output logic             m_dac_valid,
    output logic             underrun
);
    localparam int CW = OSR_DIV > 1 ? $clog2(OSR_DIV) : 1;

    logic [CW-1:0]    cnt;
    logic             tick;
    logic             accept;
    logic             pending;
    logic [WIDTH-1:0] pend_data;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] xin;
    logic [WIDTH-1:0] acc1;
    logic [WIDTH-1:0] acc2;
    logic [WIDTH:0]   s1;
    logic [WIDTH:0]   s2;
    logic             c2_d;

    assign tick               = cnt == CW'(OSR_DIV - 1);
    assign s_axis_data_tready = !pending | tick;
    assign accept             = s_axis_data_tvalid & s_axis_data_tready;

`ifdef MASH11_DITHER_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR (taps 16,15,13,4) stepping once per modulator tick
    always_ff @(posedge aclk) begin
        if (arst)
            lfsr <= 16'hACE1;
        else if (tick)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
    end

    assign xin = &x ? x : x + WIDTH'(lfsr[0]);
`else
    assign xin = x;
`endif

    assign s1 = {1'b0, acc1} + {1'b0, xin};
    assign s2 = {1'b0, acc2} + {1'b0, s1[WIDTH-1:0]};

    // Tick divider: wraps at OSR_DIV-1
    always_ff @(posedge aclk) begin
        if (arst)
            cnt <= '0;
        else
            cnt <= tick ? '0 : cnt + CW'(1);
    end

    // Input buffer: a tick drains the pending beat into x before a same-cycle beat refills it
    always_ff @(posedge aclk) begin
        if (arst) begin
            pending   <= 1'b0;
            pend_data <= '0;
            x         <= '0;
            underrun  <= 1'b0;
        end else begin
            if (accept)
                pend_data <= s_axis_data_tdata;
            if (tick) begin
                if (pending)
                    x <= pend_data;
                else
                    underrun <= 1'b1;
                pending <= accept;
            end else if (accept) begin
                pending <= 1'b1;
            end
        end
    end

    // Two cascaded error-feedback stages; code = c1 + c2 - c2_d + 1 fits 0..3
    always_ff @(posedge aclk) begin
        if (arst) begin
            acc1        <= '0;
            acc2        <= '0;
            c2_d        <= 1'b0;
            m_dac_code  <= 2'd1;
            m_dac_valid <= 1'b0;
        end else begin
            m_dac_valid <= tick;
            if (tick) begin
                acc1       <= s1[WIDTH-1:0];
                acc2       <= s2[WIDTH-1:0];
                c2_d       <= s2[WIDTH];
                m_dac_code <= {1'b0, s1[WIDTH]} + {1'b0, s2[WIDTH]} + {1'b0, ~c2_d};
            end
        end
    end
endmodule

// File: tb/tb_mash11_modulator.sv
// tb_mash11_modulator: directed vector table on an OSR_DIV=1 instance plus scoreboarded OSR_DIV=4 sequences.
module tb_mash11_modulator;
    logic        clk = 1'b0;
    logic        r1, r4, v1, v4;
    logic [15:0] d1, d4;
    logic        rd1, rd4, val1, val4, un1, un4;
    logic [1:0]  code1, code4;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mash11_modulator #(.WIDTH(16), .OSR_DIV(1)) u1 (
        .aclk(clk), .arst(r1), .s_axis_data_tdata(d1), .s_axis_data_tvalid(v1),
        .s_axis_data_tready(rd1), .m_dac_code(code1), .m_dac_valid(val1), .underrun(un1));

    mash11_modulator #(.WIDTH(16), .OSR_DIV(4)) u4 (
        .aclk(clk), .arst(r4), .s_axis_data_tdata(d4), .s_axis_data_tvalid(v4),
        .s_axis_data_tready(rd4), .m_dac_code(code4), .m_dac_valid(val4), .underrun(un4));

    typedef struct {
        logic [15:0] data;
        int          n;
        int          exp_sum;
    } vec_t;

    // OSR_DIV=4 reference model state
    int          mcnt;
    logic [15:0] mq[$];
    logic [15:0] mx, ma1, ma2, mlfsr;
    logic        mc2d, mval, mun;
    logic [1:0]  mcode;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic near(input string name, input int act, input int exp, input int tol);
        tests++;
        if (act < exp - tol || act > exp + tol) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d +-%0d", name, act, exp, tol);
        end
    endtask

    task automatic model_reset();
        mcnt = 0; mq.delete(); mx = '0; ma1 = '0; ma2 = '0; mc2d = 1'b0;
        mval = 1'b0; mun = 1'b0; mcode = 2'd1; mlfsr = 16'hACE1;
    endtask

    // One OSR_DIV=4 cycle: entered and left at a negedge
    task automatic step(input logic valid);
        logic        tk, acc;
        logic [15:0] xd;
        logic [16:0] s1, s2;
        v4 = valid;
        tk = mcnt == 3;
        chk("tready4", rd4, (mq.size() == 0) | tk);
        acc = valid & rd4;
        if (tk) begin
`ifdef MASH11_DITHER_EN
            xd = &mx ? mx : mx + {15'd0, mlfsr[0]};
            mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[14] ^ mlfsr[12] ^ mlfsr[3]};
`else
            xd = mx;
`endif
            s1 = {1'b0, ma1} + {1'b0, xd};
            s2 = {1'b0, ma2} + {1'b0, s1[15:0]};
            mcode = 2'(int'(s1[16]) + int'(s2[16]) - int'(mc2d) + 1);
            ma1 = s1[15:0]; ma2 = s2[15:0]; mc2d = s2[16];
            if (mq.size() != 0) mx = mq.pop_front();
            else mun = 1'b1;
        end
        if (acc) mq.push_back(d4);
        mval = tk;
        mcnt = tk ? 0 : mcnt + 1;
        @(posedge clk);
        #1;
        if (acc) d4 = d4 + 16'd1;
        @(negedge clk);
        chk("valid4", val4, mval);
        chk("code4", code4, mcode);
        chk("underrun4", un4, mun);
        chk("x4", u4.x, mx);
    endtask

    initial begin
        vec_t vt[6];
        int   got, guard, sum, bad;
        vt = '{'{16'h0000, 256, 0}, '{16'h8000, 256, 128}, '{16'h4000, 256, 64},
               '{16'hC000, 256, 192}, '{16'h0001, 1024, 0}, '{16'hFFFF, 65536, 65535}};
        r1 = 1'b1; r4 = 1'b1; v1 = 1'b0; v4 = 1'b0; d1 = '0; d4 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_code1", code1, 2'd1);
        chk("rst_valid1", val1, 1'b0);
        chk("rst_underrun1", un1, 1'b0);
        chk("rst_tready1", rd1, 1'b1);
        chk("rst_code4", code4, 2'd1);
        chk("rst_valid4", val4, 1'b0);
        chk("rst_underrun4", un4, 1'b0);
        chk("rst_tready4", rd4, 1'b1);

        // Constant-input vectors on OSR_DIV=1: sum of y over a window after 4 warm-up outputs
        for (int i = 0; i < 6; i++) begin
            r1 = 1'b1; d1 = vt[i].data; v1 = 1'b1;
            @(negedge clk);
            r1 = 1'b0;
            got = 0; guard = 0; sum = 0; bad = 0;
            while (got < vt[i].n + 4 && guard < vt[i].n + 64) begin
                @(negedge clk);
                guard++;
                if (val1) begin
                    if (got >= 4) sum += int'(code1) - 1;
                    if (code1 != 2'd1) bad++;
                    got++;
                end
            end
            chk($sformatf("vec%0d_outputs", i), got, vt[i].n + 4);
            chk($sformatf("vec%0d_valid_every_cycle", i), guard, got);
            near($sformatf("vec%0d_sum_y", i), sum, vt[i].exp_sum, 2);
`ifndef MASH11_DITHER_EN
            if (vt[i].data == 16'h0000) chk($sformatf("vec%0d_zero_codes", i), bad, 0);
`endif
        end
        v1 = 1'b0;

`ifdef MASH11_DITHER_EN
        r1 = 1'b1; d1 = '0; v1 = 1'b1;
        @(negedge clk);
        r1 = 1'b0;
        bad = 0;
        for (int c = 0; c < 131072 && bad == 0; c++) begin
            @(negedge clk);
            if (val1 && code1 == 2'd2) bad = 1;
        end
        chk("dither_code2_seen", bad, 1);
        v1 = 1'b0;
`endif

        // OSR_DIV=4: streaming, starvation, then reset with a pending beat
        r4 = 1'b0; d4 = 16'h1000;
        model_reset();
        for (int c = 0; c < 24; c++) step(1'b1);
        for (int c = 0; c < 12; c++) step(1'b0);
        chk("underrun_set", un4, 1'b1);
        for (int c = 0; c < 8; c++) step(1'b1);
        chk("underrun_sticky", un4, 1'b1);
        chk("pending_before_rst", mq.size(), 1);

        r4 = 1'b1; v4 = 1'b1; d4 = 16'hBEEF;
        @(negedge clk);
        chk("arst_code", code4, 2'd1);
        chk("arst_valid", val4, 1'b0);
        chk("arst_underrun", un4, 1'b0);
        chk("arst_tready", rd4, 1'b1);
        chk("arst_x", u4.x, 16'h0000);
        r4 = 1'b0;
        model_reset();
        for (int c = 0; c < 12; c++) step(1'b0);
        chk("post_rst_x", u4.x, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
